// File: rtl/led_row_capture.sv
// led_row_capture
//   Bus monitor for a HUB75-style LED panel interface. It samples the panel
//   bus in the sys_clk domain and rebuilds what a panel chain would receive.
//   It reports three kinds of result:
//     - each shifted pixel;
//     - each latched row: its bank, pixel count and a length check;
//     - each OE-low display window: its length in sys_clk cycles.
//
// Ports
//   sys_clk, sys_rst       system clock, asynchronous active-low reset
//   en                     capture enable (sys_clk domain)
//   led_clk, led_stb       panel shift clock and latch strobe (asynchronous)
//   led_oe                 panel output enable, active-low (asynchronous)
//   led_bank, led_data     panel row address and per-chain RGB data
//   px_valid/px_x/px_data  one pulse per captured pixel, with index and data
//   row_valid/row_bank/row_count/row_err
//                          one pulse per latched row, with bank, length and
//                          a length error flag
//   oe_valid/oe_bank/oe_cycles
//                          one pulse at the end of each OE-low window, with
//                          the bank of the last row and the window length
//   err_sticky             a protocol error has been seen since reset/enable
module led_row_capture #(
   parameter int C_LED_CHAINS       = 4,
   parameter int C_LED_CHAIN_LENGTH = 4,
   parameter int C_LED_NBANKS       = 16,
   parameter int C_LED_WIDTH        = 32,
   parameter int C_SYNC_STAGES      = 2,
   parameter int C_OE_CNT_WIDTH     = 24,
   localparam int N  = C_LED_WIDTH * C_LED_CHAIN_LENGTH,
   localparam int XW = (N > 1) ? $clog2(N) : 1,
   localparam int CW = $clog2(N + 1),
   localparam int BW = (C_LED_NBANKS > 1) ? $clog2(C_LED_NBANKS) : 1,
   localparam int DW = 6 * C_LED_CHAINS
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic                      en,
   input  logic                      led_clk,
   input  logic                      led_stb,
   input  logic                      led_oe,
   input  logic [BW-1:0]             led_bank,
   input  logic [DW-1:0]             led_data,
   output logic                      px_valid,
   output logic [XW-1:0]             px_x,
   output logic [DW-1:0]             px_data,
   output logic                      row_valid,
   output logic [BW-1:0]             row_bank,
   output logic [CW-1:0]             row_count,
   output logic                      row_err,
   output logic                      oe_valid,
   output logic [BW-1:0]             oe_bank,
   output logic [C_OE_CNT_WIDTH-1:0] oe_cycles,
   output logic                      err_sticky
);

   localparam int SW = 3 + BW + DW;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_WAIT_STB = 2'd1,
      ST_CAPTURE  = 2'd2
   } state_t;

   // Bundle layout: {oe, stb, clk, bank, data}. The whole bundle moves through
   // the same flops, so data and bank stay coherent with the clk/stb edges.
   logic [SW-1:0] sync_q [C_SYNC_STAGES];
   logic [SW-1:0] prev_q;
   logic [SW-1:0] cur_s;

   logic          evt_clk_rise_q, evt_stb_rise_q, evt_oe_fall_q, evt_oe_rise_q;
   logic          evt_stb_lvl_q, evt_oe_lvl_q;
   logic [BW-1:0] evt_bank_q;
   logic [DW-1:0] evt_data_q;

   state_t                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d, cnt_v;
   logic                     px_valid_q, px_valid_d;
   logic [XW-1:0]            px_x_q, px_x_d;
   logic [DW-1:0]            px_data_q, px_data_d;
   logic                     row_valid_q, row_valid_d;
   logic [BW-1:0]            row_bank_q, row_bank_d;
   logic [CW-1:0]            row_count_q, row_count_d;
   logic                     row_err_q, row_err_d;
   logic                     oe_valid_q, oe_valid_d;
   logic [BW-1:0]            oe_bank_q, oe_bank_d;
   logic [C_OE_CNT_WIDTH-1:0] oe_cycles_q, oe_cycles_d;
   logic [C_OE_CNT_WIDTH-1:0] oe_cnt_q, oe_cnt_d;
   logic                     oe_armed_q, oe_armed_d;
   logic                     err_q, err_d;

   assign cur_s = sync_q[C_SYNC_STAGES-1];

   // Synchronizer chain plus the previous-value flop used for edge detection.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         for (int i = 0; i < C_SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= {led_oe, led_stb, led_clk, led_bank, led_data};
         for (int i = 1; i < C_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= cur_s;
      end
   end

   // Registered edge events and the coherent data/bank sampled with them.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         evt_clk_rise_q <= 1'b0;
         evt_stb_rise_q <= 1'b0;
         evt_oe_fall_q  <= 1'b0;
         evt_oe_rise_q  <= 1'b0;
         evt_stb_lvl_q  <= 1'b0;
         evt_oe_lvl_q   <= 1'b0;
         evt_bank_q     <= '0;
         evt_data_q     <= '0;
      end else begin
         evt_clk_rise_q <= cur_s[BW+DW]     & ~prev_q[BW+DW];
         evt_stb_rise_q <= cur_s[BW+DW+1]   & ~prev_q[BW+DW+1];
         evt_oe_fall_q  <= ~cur_s[BW+DW+2]  & prev_q[BW+DW+2];
         evt_oe_rise_q  <= cur_s[BW+DW+2]   & ~prev_q[BW+DW+2];
         evt_stb_lvl_q  <= cur_s[BW+DW+1];
         evt_oe_lvl_q   <= cur_s[BW+DW+2];
         evt_bank_q     <= cur_s[BW+DW-1:DW];
         evt_data_q     <= cur_s[DW-1:0];
      end
   end

   // Next-state and next-output logic for the capture FSM.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cnt_v       = cnt_q;
      px_valid_d  = 1'b0;
      px_x_d      = px_x_q;
      px_data_d   = px_data_q;
      row_valid_d = 1'b0;
      row_bank_d  = row_bank_q;
      row_count_d = row_count_q;
      row_err_d   = row_err_q;
      oe_valid_d  = 1'b0;
      oe_bank_d   = oe_bank_q;
      oe_cycles_d = oe_cycles_q;
      oe_cnt_d    = oe_cnt_q;
      oe_armed_d  = oe_armed_q;
      err_d       = err_q;

      if (!en) begin
         // Disabled: every output and counter back to its reset value.
         state_d     = ST_DISABLED;
         cnt_d       = '0;
         px_x_d      = '0;
         px_data_d   = '0;
         row_bank_d  = '0;
         row_count_d = '0;
         row_err_d   = 1'b0;
         oe_bank_d   = '0;
         oe_cycles_d = '0;
         oe_cnt_d    = '0;
         oe_armed_d  = 1'b0;
         err_d       = 1'b0;
      end else begin
         case (state_q)
            ST_DISABLED: begin
               state_d = ST_WAIT_STB;
               err_d   = 1'b0;
            end
            ST_WAIT_STB: begin
               if (evt_stb_rise_q) begin
                  cnt_d     = '0;
                  oe_bank_d = evt_bank_q;
                  state_d   = ST_CAPTURE;
               end else begin
                  state_d = ST_WAIT_STB;
               end
            end
            ST_CAPTURE: begin
               if (evt_clk_rise_q) begin
                  if (cnt_q == CW'(N)) begin
                     err_d = 1'b1;
                  end else begin
                     px_valid_d = 1'b1;
                     px_x_d     = cnt_q[XW-1:0];
                     px_data_d  = evt_data_q;
                     cnt_v      = cnt_q + CW'(1);
                  end
                  // A shift while the latch is open is a protocol error,
                  // except the coincident edge that closes the row.
                  if (evt_stb_lvl_q && !evt_stb_rise_q) begin
                     err_d = 1'b1;
                  end else begin
                     err_d = err_d;
                  end
               end else begin
                  cnt_v = cnt_q;
               end
               // The coincident pixel has already been counted into cnt_v.
               if (evt_stb_rise_q) begin
                  row_valid_d = 1'b1;
                  row_count_d = cnt_v;
                  row_err_d   = (cnt_v != CW'(N));
                  row_bank_d  = evt_bank_q;
                  oe_bank_d   = evt_bank_q;
                  cnt_d       = '0;
               end else begin
                  cnt_d = cnt_v;
               end
               if (evt_oe_fall_q) begin
                  oe_cnt_d   = C_OE_CNT_WIDTH'(1);
                  oe_armed_d = 1'b1;
               end else if (evt_oe_rise_q) begin
                  // A rise is reported only if its fall was seen in CAPTURE.
                  if (oe_armed_q) begin
                     oe_valid_d  = 1'b1;
                     oe_cycles_d = oe_cnt_q;
                  end else begin
                     oe_valid_d = 1'b0;
                  end
                  oe_armed_d = 1'b0;
               end else if (oe_armed_q && !evt_oe_lvl_q && (oe_cnt_q != '1)) begin
                  oe_cnt_d = oe_cnt_q + C_OE_CNT_WIDTH'(1);
               end else begin
                  oe_cnt_d = oe_cnt_q;
               end
            end
            default: begin
               state_d = ST_DISABLED;
            end
         endcase
      end
   end

   // FSM state and output registers.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q     <= ST_DISABLED;
         cnt_q       <= '0;
         px_valid_q  <= 1'b0;
         px_x_q      <= '0;
         px_data_q   <= '0;
         row_valid_q <= 1'b0;
         row_bank_q  <= '0;
         row_count_q <= '0;
         row_err_q   <= 1'b0;
         oe_valid_q  <= 1'b0;
         oe_bank_q   <= '0;
         oe_cycles_q <= '0;
         oe_cnt_q    <= '0;
         oe_armed_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         px_valid_q  <= px_valid_d;
         px_x_q      <= px_x_d;
         px_data_q   <= px_data_d;
         row_valid_q <= row_valid_d;
         row_bank_q  <= row_bank_d;
         row_count_q <= row_count_d;
         row_err_q   <= row_err_d;
         oe_valid_q  <= oe_valid_d;
         oe_bank_q   <= oe_bank_d;
         oe_cycles_q <= oe_cycles_d;
         oe_cnt_q    <= oe_cnt_d;
         oe_armed_q  <= oe_armed_d;
         err_q       <= err_d;
      end
   end

   assign px_valid   = px_valid_q;
   assign px_x       = px_x_q;
   assign px_data    = px_data_q;
   assign row_valid  = row_valid_q;
   assign row_bank   = row_bank_q;
   assign row_count  = row_count_q;
   assign row_err    = row_err_q;
   assign oe_valid   = oe_valid_q;
   assign oe_bank    = oe_bank_q;
   assign oe_cycles  = oe_cycles_q;
   assign err_sticky = err_q;

endmodule

// File: tb/tb_led_row_capture.sv
// tb_led_row_capture
//   Drives panel bus traffic into led_row_capture and checks the reported
//   pixels, rows and OE windows against a count-based reference model and a
//   table of row vectors.
module tb_led_row_capture;

   localparam int N  = 128;
   localparam int XW = 7;
   localparam int CW = 8;
   localparam int BW = 4;
   localparam int DW = 24;
   localparam int OW = 24;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b0;
   logic          en = 1'b0;
   logic          led_clk = 1'b0;
   logic          led_stb = 1'b0;
   logic          led_oe = 1'b1;
   logic [BW-1:0] led_bank = '0;
   logic [DW-1:0] led_data = '0;
   logic          px_valid, row_valid, row_err, oe_valid, err_sticky;
   logic [XW-1:0] px_x;
   logic [DW-1:0] px_data;
   logic [BW-1:0] row_bank, oe_bank;
   logic [CW-1:0] row_count;
   logic [OW-1:0] oe_cycles;

   led_row_capture dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en),
      .led_clk(led_clk), .led_stb(led_stb), .led_oe(led_oe),
      .led_bank(led_bank), .led_data(led_data),
      .px_valid(px_valid), .px_x(px_x), .px_data(px_data),
      .row_valid(row_valid), .row_bank(row_bank), .row_count(row_count),
      .row_err(row_err), .oe_valid(oe_valid), .oe_bank(oe_bank),
      .oe_cycles(oe_cycles), .err_sticky(err_sticky)
   );

   always #5 sys_clk = ~sys_clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Captured and expected records: px {x,data}, row {count,err,bank}, oe {cycles,bank}.
   logic [XW+DW-1:0]  got_px[$],  exp_px[$];
   logic [CW+BW:0]    got_row[$], exp_row[$];
   logic [OW+BW-1:0]  got_oe[$],  exp_oe[$];

   // Reference model state: is a row open, pixels so far, errors, last bank.
   bit            m_active = 1'b0;
   int            m_cnt = 0;
   bit            m_err = 1'b0;
   logic [BW-1:0] m_oe_bank = '0;

   typedef struct {
      int            npix;
      logic [BW-1:0] bank;
      int            exp_count;
      bit            exp_err;
   } vec_t;
   vec_t vecs[6];

   // Output monitor, sampling away from the active edge.
   always @(posedge sys_clk) begin
      #1;
      if (px_valid)  got_px.push_back({px_x, px_data});
      if (row_valid) got_row.push_back({row_count, row_err, row_bank});
      if (oe_valid)  got_oe.push_back({oe_cycles, oe_bank});
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
      n_cmp++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, got, req);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic model_pixel(input logic [DW-1:0] d);
      if (m_active) begin
         if (m_cnt < N) begin
            exp_px.push_back({XW'(m_cnt), d});
            m_cnt++;
         end else begin
            m_err = 1'b1;
         end
      end
   endtask

   task automatic model_stb(input logic [BW-1:0] b);
      if (m_active) exp_row.push_back({CW'(m_cnt), (m_cnt != N), b});
      m_cnt     = 0;
      m_active  = 1'b1;
      m_oe_bank = b;
   endtask

   task automatic drive_pixel(input logic [DW-1:0] d);
      led_data = d;
      cycles(2);
      led_clk = 1'b1;
      cycles(2);
      led_clk = 1'b0;
      cycles(2);
      if (en) model_pixel(d);
   endtask

   task automatic strobe(input logic [BW-1:0] b);
      led_bank = b;
      cycles(2);
      led_stb = 1'b1;
      cycles(2);
      led_stb = 1'b0;
      cycles(2);
      if (en) model_stb(b);
   endtask

   // Let the pipeline drain, then compare every captured record with the model.
   task automatic compare_all(input string tag);
      cycles(10);
      chk({tag, "_px_n"},  64'(got_px.size()),  64'(exp_px.size()));
      for (int i = 0; i < got_px.size() && i < exp_px.size(); i++)
         chk({tag, "_px"}, 64'(got_px[i]), 64'(exp_px[i]));
      chk({tag, "_row_n"}, 64'(got_row.size()), 64'(exp_row.size()));
      for (int i = 0; i < got_row.size() && i < exp_row.size(); i++)
         chk({tag, "_row"}, 64'(got_row[i]), 64'(exp_row[i]));
      chk({tag, "_oe_n"},  64'(got_oe.size()),  64'(exp_oe.size()));
      for (int i = 0; i < got_oe.size() && i < exp_oe.size(); i++)
         chk({tag, "_oe"}, 64'(got_oe[i]), 64'(exp_oe[i]));
      chk({tag, "_err_sticky"}, 64'(err_sticky), 64'(m_err));
      got_px.delete();  exp_px.delete();
      got_row.delete(); exp_row.delete();
      got_oe.delete();  exp_oe.delete();
   endtask

   initial begin
      logic [DW-1:0] d;
      logic [CW+BW:0] tbl_req;

      vecs[0] = '{npix: 100, bank: 4'd1, exp_count: 100, exp_err: 1'b1};
      vecs[1] = '{npix: 128, bank: 4'd2, exp_count: 128, exp_err: 1'b0};
      vecs[2] = '{npix: 0,   bank: 4'd4, exp_count: 0,   exp_err: 1'b1};
      vecs[3] = '{npix: 1,   bank: 4'd6, exp_count: 1,   exp_err: 1'b1};
      vecs[4] = '{npix: 127, bank: 4'd8, exp_count: 127, exp_err: 1'b1};
      vecs[5] = '{npix: 130, bank: 4'd9, exp_count: 128, exp_err: 1'b0};

      // Reset held with a busy bus: nothing may come out.
      en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge sys_clk);
         led_clk  = 1'($urandom_range(1, 0));
         led_stb  = 1'($urandom_range(1, 0));
         led_oe   = 1'($urandom_range(1, 0));
         led_bank = 4'($urandom);
         led_data = 24'($urandom);
      end
      @(posedge sys_clk); #1;
      chk("reset_outputs",
          64'({px_valid, px_x, px_data, row_valid, row_bank, row_count, row_err,
               oe_valid, oe_bank, oe_cycles, err_sticky}), 64'd0);
      led_clk = 1'b0; led_stb = 1'b0; led_oe = 1'b1;
      cycles(4);
      chk("reset_no_pulses", 64'(got_px.size() + got_row.size() + got_oe.size()), 64'd0);
      sys_rst = 1'b1;
      cycles(3);

      // Shifts before the first strobe are ignored.
      for (int i = 0; i < 5; i++) drive_pixel(24'(i + 500));
      compare_all("pre_stb");

      // Full row with data = pixel index, closed with bank 5.
      strobe(4'd0);
      for (int i = 0; i < N; i++) drive_pixel(24'(i));
      strobe(4'd5);
      compare_all("full_row");

      // 127 pixels, then clk and stb rising together.
      for (int i = 0; i < N - 1; i++) drive_pixel(24'($urandom));
      d = 24'($urandom);
      led_data = d; led_bank = 4'd7;
      cycles(2);
      led_clk = 1'b1; led_stb = 1'b1;
      cycles(2);
      led_clk = 1'b0; led_stb = 1'b0;
      cycles(2);
      model_pixel(d);
      model_stb(4'd7);
      drive_pixel(24'h00abcd);
      strobe(4'd10);
      compare_all("coincident");

      // Table of row lengths with random data.
      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < vecs[v].npix; i++) drive_pixel(24'($urandom));
         strobe(vecs[v].bank);
         cycles(10);
         tbl_req = {CW'(vecs[v].exp_count), vecs[v].exp_err, vecs[v].bank};
         chk("tbl_row_n", 64'(got_row.size()), 64'd1);
         if (got_row.size() > 0) chk("tbl_row", 64'(got_row[0]), 64'(tbl_req));
         got_row.delete(); exp_row.delete();
         compare_all("tbl_px");
      end

      // OE low for exactly 1000 cycles after a row latched with bank 3.
      strobe(4'd3);
      led_oe = 1'b0;
      cycles(1000);
      led_oe = 1'b1;
      exp_oe.push_back({OW'(1000), m_oe_bank});
      compare_all("oe_window");
      chk("oe_bank", 64'(oe_bank), 64'd3);

      // Drop enable mid-row: outputs clear on the next cycle.
      for (int i = 0; i < 10; i++) drive_pixel(24'($urandom));
      cycles(3);
      en = 1'b0;
      m_active = 1'b0; m_err = 1'b0; m_cnt = 0;
      @(posedge sys_clk); #1;
      chk("disable_outputs",
          64'({px_valid, px_x, px_data, row_valid, row_bank, row_count, row_err,
               oe_valid, oe_bank, oe_cycles, err_sticky}), 64'd0);
      got_px.delete(); exp_px.delete();
      for (int i = 0; i < 4; i++) drive_pixel(24'($urandom));

      // Enable during a burst: silent until a strobe, then a full row.
      led_data = 24'h123456;
      cycles(2);
      led_clk = 1'b1;
      en = 1'b1;
      cycles(2);
      led_clk = 1'b0;
      cycles(2);
      for (int i = 0; i < 6; i++) drive_pixel(24'($urandom));
      strobe(4'd11);
      for (int i = 0; i < N; i++) drive_pixel(24'($urandom));
      strobe(4'd12);
      compare_all("reenable");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_row_capture.md
# led_row_capture

Receive-side counterpart of the LED panel blitter: watches the HUB75-style panel bus (led_clk, led_stb, led_oe, led_bank, per-chain RGB data) in the sys_clk domain and reconstructs what a panel chain would see. It emits:
- one pulse per shifted pixel;
- one summary per latched row, with bank, pixel count and length check;
- one measurement per OE-low display window.

It is used for loopback self-test on the board and as the bus monitor in simulation.

## Interface
Parameters:
- C_LED_CHAINS, 4, number of display chains (6 data bits each: R0 G0 B0 R1 G1 B1)
- C_LED_CHAIN_LENGTH, 4, displays per chain
- C_LED_NBANKS, 16, banks per chain
- C_LED_WIDTH, 32, pixels per display row
- C_SYNC_STAGES, 2, synchronizer depth (≥2)
- C_OE_CNT_WIDTH, 24, width of OE window counter

Derived: N = C_LED_WIDTH*C_LED_CHAIN_LENGTH; XW = $clog2(N); CW = $clog2(N+1); BW = $clog2(C_LED_NBANKS).

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-low reset
- en  in  1  capture enable
- led_clk  in  1  panel shift clock (asynchronous)
- led_stb  in  1  panel latch strobe
- led_oe  in  1  panel output enable, active-low
- led_bank  in  BW  panel row address
- led_data  in  6*C_LED_CHAINS  panel RGB data
- px_valid  out  1  one-cycle pulse per captured pixel
- px_x  out  XW  pixel index within row
- px_data  out  6*C_LED_CHAINS  data sampled at led_clk rise
- row_valid  out  1  one-cycle pulse per latched row
- row_bank  out  BW  led_bank sampled at strobe rise
- row_count  out  CW  pixels shifted since previous strobe
- row_err  out  1  row_count != N (valid with row_valid)
- oe_valid  out  1  one-cycle pulse at end of OE-low window
- oe_bank  out  BW  bank of last latched row
- oe_cycles  out  C_OE_CNT_WIDTH  sys_clk cycles OE was low, saturating
- err_sticky  out  1  protocol error seen since reset/enable

## Operation
Input conditioning:
- All bus inputs pass through C_SYNC_STAGES flops as one bundle, plus one "previous" flop.
- Edges are detected on the last stage: rise = s & ~prev, fall = ~s & prev.
- Data and bank come from the same stage as led_clk and led_stb, so they are coherent.

FSM states:
- DISABLED: entered on reset or when en=0. Outputs are held at their reset values. Synchronizers keep running.
- WAIT_STB: entered when en rises. All edges are ignored until a led_stb rise. That rise clears the pixel counter, samples the bank into oe_bank, emits no row_valid, and moves the FSM to CAPTURE.
- CAPTURE: normal operation, described below. Any cycle with en=0 returns the FSM to DISABLED.

CAPTURE behaviour:
- **led_clk rise:**
  - px_valid=1, px_x=pixel counter, px_data=synced data.
  - The counter increments, saturating at N.
  - A rise while the counter is already N sets err_sticky, and no px_valid is emitted.
- **led_stb rise:**
  - row_valid=1, row_count=counter, row_err=(counter!=N), row_bank=synced bank.
  - oe_bank is updated to the same bank.
  - The counter clears to 0.
- **Same cycle as clk rise and stb rise:** the pixel is counted into the closing row first. It appears in row_count, and the counter then clears to 0.
- **led_clk rise while synced led_stb is high:** sets err_sticky; the pixel is still captured.
- **OE measurement:**
  - On an led_oe fall, the OE counter loads 1.
  - While led_oe stays low, it increments each cycle, saturating at all-ones.
  - On the led_oe rise: oe_valid=1, oe_cycles=count.
  - An OE rise without a preceding fall in CAPTURE emits nothing.
- err_sticky clears only on reset or on entry to WAIT_STB.

## Timing
- Latency: a bus input level first sampled at sys_clk edge k produces its output pulse in the cycle after edge k+C_SYNC_STAGES+1. That is C_SYNC_STAGES+2 cycles: 4 with the default.
- All outputs are registered. Pulses last exactly one cycle.
- px_x, px_data, row_* and oe_cycles/oe_bank hold their values until the next pulse of their group.
- Input requirements: led_clk high and low phases ≥2 sys_clk cycles each. Data and bank stable from 2 cycles before to 1 cycle after each led_clk rise.
- Reset values: all outputs 0; FSM in DISABLED; counters 0.
- Reset asserted mid-row: everything clears immediately and asynchronously. After release, the FSM enters WAIT_STB only if en=1.

## Test plan
- Reset: hold sys_rst=0 with the bus toggling → every output 0, no pulses; after release with en=1, no px_valid until the first led_stb rise.
- Full row: stb, 128 clk pulses with data=pixel index, stb with bank=5 (defaults) → px_valid ×128 with px_x 0..127 and matching px_data; row_valid with row_count=128, row_err=0, row_bank=5.
- Short row and overrun:
  - 100 clks then stb → row_count=100, row_err=1.
  - Next row with 130 clks → 128 px_valid pulses, err_sticky=1.
- OE window: led_oe low for 1000 sys_clk cycles after a row latched with bank 3 → oe_valid with oe_cycles=1000±1 (sync alignment) and oe_bank=3.
- Coincident edges: clk rise and stb rise in the same sync cycle after 127 pixels → px_x=127, then row_count=128, row_err=0; the next row starts at px_x=0.
- Enable mid-row: en rises during a burst → no outputs until stb; the following full row reports row_count=128. Dropping en mid-row → pulses stop on the next cycle.
